// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream and window-output bundle for line_buffer_ctrl.
// master = upstream/consumer side, slave = the controller itself.
interface line_buffer_ctrl_if;
  logic [7:0]  in_pixel_data;
  logic        in_pixel_valid;
  logic        in_ready;
  logic [71:0] out_pixels_data;
  logic        out_pixels_valid;
  logic        line_done_intr;

  modport master (
    output in_pixel_data,
    output in_pixel_valid,
    input  in_ready,
    input  out_pixels_data,
    input  out_pixels_valid,
    input  line_done_intr
  );

  modport slave (
    input  in_pixel_data,
    input  in_pixel_valid,
    output in_ready,
    output out_pixels_data,
    output out_pixels_valid,
    output line_done_intr
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// 4-line rotating buffer feeding 3x3 windows to the convolution stage.
// Define LB_HPAD_EN for horizontal zero padding (IMG_WIDTH windows per row).
module line_buffer_ctrl #(
  parameter int IMG_WIDTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  line_buffer_ctrl_if.slave  bus
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
`ifdef LB_HPAD_EN
  localparam int LAST_COL = IMG_WIDTH - 1;
  localparam int HPAD_OFS = -1;
`else
  localparam int LAST_COL = IMG_WIDTH - 3;
  localparam int HPAD_OFS = 0;
`endif
  localparam logic [COL_W-1:0] WR_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] RD_LAST = COL_W'(LAST_COL);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [4][IMG_WIDTH];
  logic [1:0]       r_wr_buf;
  logic [1:0]       r_rd_buf;
  logic [COL_W-1:0] r_wr_col;
  logic [COL_W-1:0] r_rd_col;
  logic [COL_W-1:0] w_rd_col_nxt;
  logic [2:0]       r_lines;
  logic [2:0]       w_lines_nxt;
  logic             r_ready;
  logic             w_accept;
  logic             w_wr_wrap;
  logic             w_win_en;
  logic             w_rd_done;
  logic [71:0]      w_win;
  int               w_col;
  logic [1:0]       w_buf;
  logic [71:0]      r_win_p1;
  logic             r_vld_p1;
  logic             r_rel_p1;
  logic             r_intr_p2;

  // Occupancy moves by at most one per cycle; a wrap and a release together cancel.
  function automatic logic [2:0] lines_update(input logic [2:0] cur,
                                              input logic       inc,
                                              input logic       dec);
    logic [2:0] res;
    res = cur;
    if (inc && !dec && (cur < 3'd4))
      res = cur + 3'd1;
    else if (dec && !inc && (cur != 3'd0))
      res = cur - 3'd1;
    return res;
  endfunction

  assign w_accept    = bus.in_pixel_valid && r_ready;
  assign w_wr_wrap   = w_accept && (r_wr_col == WR_LAST);
  assign w_lines_nxt = lines_update(r_lines, w_wr_wrap, w_rd_done);

  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_wr_buf][r_wr_col] <= bus.in_pixel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_buf <= '0;
      r_wr_col <= '0;
      r_lines  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_col <= w_wr_wrap ? '0 : r_wr_col + 1'b1;
        if (w_wr_wrap)
          r_wr_buf <= r_wr_buf + 2'd1;
      end
      r_lines <= w_lines_nxt;
      r_ready <= (w_lines_nxt < 3'd4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd_col <= '0;
      r_rd_buf <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_col <= w_rd_col_nxt;
      if (w_rd_done)
        r_rd_buf <= r_rd_buf + 2'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_col_nxt = r_rd_col;
    w_win_en     = 1'b0;
    w_rd_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rd_col_nxt = '0;
        if (r_lines >= 3'd3)
          w_state_nxt = S_READ;
      end
      S_READ: begin
        w_win_en     = 1'b1;
        w_rd_col_nxt = r_rd_col + 1'b1;
        if (r_rd_col == RD_LAST) begin
          w_rd_done    = 1'b1;
          w_rd_col_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row 0 is the oldest buffer; out-of-image columns read as zero.
  always_comb begin
    w_win = '0;
    w_col = 0;
    w_buf = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        w_col = int'(r_rd_col) + k + HPAD_OFS;
        w_buf = r_rd_buf + 2'(r);
        if ((w_col >= 0) && (w_col < IMG_WIDTH))
          w_win[(r*3+k)*8 +: 8] = r_mem[w_buf][w_col[COL_W-1:0]];
      end
    end
  end

  // p1: registered window/valid; p2: release pulse lands after the last window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_rel_p1  <= 1'b0;
      r_intr_p2 <= 1'b0;
    end else begin
      if (w_win_en)
        r_win_p1 <= w_win;
      r_vld_p1  <= w_win_en;
      r_rel_p1  <= w_rd_done;
      r_intr_p2 <= r_rel_p1;
    end
  end

  assign bus.in_ready         = r_ready;
  assign bus.out_pixels_data  = r_win_p1;
  assign bus.out_pixels_valid = r_vld_p1;
  assign bus.line_done_intr   = r_intr_p2;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl at IMG_WIDTH=8 (pixel = row*16+col).
// Expectations follow LB_HPAD_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_line_buffer_ctrl;
  localparam int W = 8;
`ifdef LB_HPAD_EN
  localparam int NW  = W;
  localparam int OFF = -1;
`else
  localparam int NW  = W - 2;
  localparam int OFF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_buffer_ctrl_if bus();
  line_buffer_ctrl #(.IMG_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: windows, interrupt cycles, last accepted pixel edge, in_ready stalls.
  logic [71:0] q_win[$];
  int          q_wcyc[$];
  int          q_icyc[$];
  int          last_acc = 0;
  int          ready_low = 0;
  always @(negedge clk) begin
    if (bus.out_pixels_valid) begin
      q_win.push_back(bus.out_pixels_data);
      q_wcyc.push_back(cyc);
    end
    if (bus.line_done_intr) q_icyc.push_back(cyc);
    if (bus.in_pixel_valid && bus.in_ready) last_acc = cyc + 1;
    if (rst_n && !bus.in_ready) ready_low++;
  end

  logic [7:0] m_img [16][W];

  function automatic logic [71:0] exp_win(input int top, input int c);
    logic [71:0] w;
    int col;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        col = c + k + OFF;
        w[(r*3+k)*8 +: 8] = (col < 0 || col >= W) ? 8'h00 : m_img[top+r][col];
      end
    return w;
  endfunction

  function automatic logic [71:0] win_at(input int i);
    return (i < q_win.size()) ? q_win[i] : 72'hx;
  endfunction

  function automatic int wcyc_at(input int i);
    return (i < q_wcyc.size()) ? q_wcyc[i] : -1000;
  endfunction

  function automatic int icyc_at(input int i);
    return (i < q_icyc.size()) ? q_icyc[i] : -1000;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 72'(bus.out_pixels_valid), 72'd0);
    chk({tag, "_data"},  bus.out_pixels_data,       72'd0);
    chk({tag, "_intr"},  72'(bus.line_done_intr),   72'd0);
    chk({tag, "_ready"}, 72'(bus.in_ready),         72'd0);
  endtask

  task automatic apply_reset();
    bus.in_pixel_valid = 1'b0;
    bus.in_pixel_data  = 8'h00;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_ready", 72'(bus.in_ready), 72'd1);
  endtask

  // mode 0: continuous, 1: valid toggles 0/1, 2: random idle gaps
  task automatic send(input logic [7:0] d, input int mode);
    int g;
    bit acc;
    if (mode == 1) begin
      bus.in_pixel_valid = 1'b0;
      @(posedge clk); #1;
    end else if (mode == 2) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_pixel_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_pixel_valid = 1'b1;
    bus.in_pixel_data  = d;
    g = 0;
    do begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: pixel %h not accepted within %0d cycles", d, g);
    end
    bus.in_pixel_valid = 1'b0;
  endtask

  task automatic stream(input logic [7:0] base, input int n, input int mode, input bit rnd);
    logic [7:0] px;
    for (int l = 0; l < n; l++)
      for (int c = 0; c < W; c++) begin
        px = rnd ? 8'($urandom) : base + 8'(l*16 + c);
        m_img[l][c] = px;
        send(px, mode);
      end
  endtask

  task automatic wait_wins(input int target);
    int g;
    g = 0;
    while (q_win.size() < target && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag, input int w0, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < NW; c++)
        chk($sformatf("%s_r%0d_c%0d", tag, r, c), win_at(w0 + r*NW + c), exp_win(r, c));
  endtask

  typedef struct {
    string       name;
    logic [7:0]  base;
    int          mode;
    logic [71:0] first;
    logic [71:0] last;
  } vec_t;

  vec_t tbl[3];
  int   w0, i0, r0, wv, ok;

  initial begin
`ifdef LB_HPAD_EN
    tbl[0] = '{"lines012",     8'h00, 0, 72'h212000111000010000, 72'h002726001716000706};
    tbl[1] = '{"toggle_valid", 8'h00, 1, 72'h212000111000010000, 72'h002726001716000706};
    tbl[2] = '{"offset40",     8'h40, 0, 72'h616000515000414000, 72'h006766005756004746};
`else
    tbl[0] = '{"lines012",     8'h00, 0, 72'h222120121110020100, 72'h272625171615070605};
    tbl[1] = '{"toggle_valid", 8'h00, 1, 72'h222120121110020100, 72'h272625171615070605};
    tbl[2] = '{"offset40",     8'h40, 0, 72'h626160525150424140, 72'h676665575655474645};
`endif
    bus.in_pixel_valid = 1'b0;
    bus.in_pixel_data  = 8'h00;
    #3 chk_outputs_zero("por");

    // Three-line runs from the vector table
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      w0 = q_win.size();
      i0 = q_icyc.size();
      stream(tbl[t].base, 3, tbl[t].mode, 1'b0);
      wait_wins(w0 + NW);
      chk({tbl[t].name, "_count"},   72'(q_win.size() - w0), 72'(NW));
      chk({tbl[t].name, "_first"},   win_at(w0), tbl[t].first);
      chk({tbl[t].name, "_last"},    win_at(w0 + NW - 1), tbl[t].last);
      chk({tbl[t].name, "_latency"}, 72'(wcyc_at(w0) - last_acc), 72'd2);
      chk({tbl[t].name, "_b2b"},     72'(wcyc_at(w0 + NW - 1) - wcyc_at(w0)), 72'(NW - 1));
      chk({tbl[t].name, "_intr_n"},  72'(q_icyc.size() - i0), 72'd1);
      chk({tbl[t].name, "_intr_at"}, 72'(icyc_at(i0) - wcyc_at(w0 + NW - 1)), 72'd1);
    end

    // Ten continuous lines
    apply_reset();
    w0 = q_win.size();
    i0 = q_icyc.size();
    r0 = ready_low;
    stream(8'h00, 10, 0, 1'b0);
    wait_wins(w0 + 8*NW);
    chk("ten_count", 72'(q_win.size() - w0), 72'(8*NW));
    chk("ten_intr",  72'(q_icyc.size() - i0), 72'd8);
    chk("ten_ready", 72'(ready_low - r0), 72'd0);
    ok = 1;
    for (int r = 0; r < 7; r++)
      if (wcyc_at(w0 + (r+1)*NW) - wcyc_at(w0 + r*NW + NW - 1) < 2) ok = 0;
    chk("ten_row_gap", 72'(ok), 72'd1);
    for (int r = 0; r < 8; r++)
`ifdef LB_HPAD_EN
      chk($sformatf("ten_row%0d_byte0", r), 72'(win_at(w0 + r*NW) & 72'hff), 72'd0);
`else
      chk($sformatf("ten_row%0d_byte0", r), 72'(win_at(w0 + r*NW) & 72'hff), 72'(r*16));
`endif
    cmp_model("ten", w0, 8);

    // Reset during row-0 readout, then a fresh image offset by 0x40
    apply_reset();
    i0 = q_icyc.size();
    w0 = q_win.size();
    stream(8'h00, 3, 0, 1'b0);
    begin
      int g;
      g = 0;
      while (q_win.size() < w0 + 3 && g < 100) begin
        @(posedge clk);
        g++;
      end
    end
    chk("midrow_reached3", 72'(q_win.size() >= w0 + 3), 72'd1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midrow_rst");
    wv = q_win.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrow_no_more_win", 72'(q_win.size()), 72'(wv));
    chk("midrow_no_intr",     72'(q_icyc.size() - i0), 72'd0);
    chk("midrow_ready",       72'(bus.in_ready), 72'd1);
    w0 = q_win.size();
    stream(8'h40, 3, 0, 1'b0);
    wait_wins(w0 + NW);
    chk("midrow_new_first", win_at(w0), tbl[2].first);
    chk("midrow_new_count", 72'(q_win.size() - w0), 72'(NW));

    // Random pixels with random gaps against the reference model
    apply_reset();
    w0 = q_win.size();
    i0 = q_icyc.size();
    stream(8'h00, 5, 2, 1'b1);
    wait_wins(w0 + 3*NW);
    chk("rand_count", 72'(q_win.size() - w0), 72'(3*NW));
    chk("rand_intr",  72'(q_icyc.size() - i0), 72'd3);
    cmp_model("rand", w0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
